// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate in either direction, parallel load
// and hold. A counter tracks shifts within the current WIDTH-bit word. word_o
// pulses on the edge that completes a word.
module universal_shift_register #(
   parameter int              WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int             CW          = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [2:0]       mode_i,
   input  logic             ser_i,
   input  logic [WIDTH-1:0] load_i,
   output logic [WIDTH-1:0] out_o,
   output logic             ser_o,
   output logic [CW-1:0]    count_o,
   output logic             word_o
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;

   localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    count_q, count_d;
   logic             word_q, word_d;
   logic             counted_op;

   // Next-state: data path per mode, plus the word counter for shift/rotate ops
   always_comb begin
      data_d     = data_q;
      count_d    = count_q;
      word_d     = 1'b0;
      counted_op = 1'b0;
      if (en_i) begin
         case (mode_i)
            MODE_SHL: begin
               data_d     = {data_q[WIDTH-2:0], ser_i};
               counted_op = 1'b1;
            end
            MODE_SHR: begin
               data_d     = {ser_i, data_q[WIDTH-1:1]};
               counted_op = 1'b1;
            end
            MODE_ROL: begin
               data_d     = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
               counted_op = 1'b1;
            end
            MODE_ROR: begin
               data_d     = {data_q[0], data_q[WIDTH-1:1]};
               counted_op = 1'b1;
            end
            MODE_LOAD: begin
               data_d  = load_i;
               count_d = '0;
            end
            default: begin
               // hold and the reserved encodings leave everything unchanged
               data_d = data_q;
            end
         endcase
         if (counted_op) begin
            if (count_q == COUNT_LAST) begin
               count_d = '0;
               word_d  = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
      end
   end

   // State registers with synchronous reset taking priority over everything
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= RESET_VALUE;
         count_q <= '0;
         word_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
         word_q  <= word_d;
      end
   end

   // Serial out is the bit the next shift in the selected direction drops
   always_comb begin
      ser_o = data_q[WIDTH-1];
      if (mode_i == MODE_SHR || mode_i == MODE_ROR) begin
         ser_o = data_q[0];
      end
   end

   assign out_o   = data_q;
   assign count_o = count_q;
   assign word_o  = word_q;

   // MODE_HOLD is covered by the default branch; referenced here for clarity
   logic unused_hold;
   assign unused_hold = ^MODE_HOLD;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register (WIDTH=16) with a behavioural model.
module tb_universal_shift_register;

   localparam int W = 16;

   logic          clk;
   logic          reset;
   logic          en_i;
   logic [2:0]    mode_i;
   logic          ser_i;
   logic [W-1:0]  load_i;
   logic [W-1:0]  out_o;
   logic          ser_o;
   logic [3:0]    count_o;
   logic          word_o;

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   // behavioural model state
   int m_q;
   int m_cnt;
   bit m_word;

   universal_shift_register #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
      .clk(clk), .reset(reset), .en_i(en_i), .mode_i(mode_i), .ser_i(ser_i),
      .load_i(load_i), .out_o(out_o), .ser_o(ser_o), .count_o(count_o),
      .word_o(word_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of one clock edge, expressed as integer arithmetic on the word
   task automatic model_edge(input bit r, input bit e, input int md, input bit s, input int ld);
      int full;
      int half;
      full   = 1 << W;
      half   = 1 << (W - 1);
      m_word = 0;
      if (r) begin
         m_q   = 0;
         m_cnt = 0;
      end else if (e) begin
         if (md >= 1 && md <= 4) begin
            case (md)
               1: m_q = (m_q * 2 + s) % full;
               2: m_q = m_q / 2 + s * half;
               3: m_q = (m_q * 2) % full + m_q / half;
               default: m_q = m_q / 2 + (m_q % 2) * half;
            endcase
            if (m_cnt == W - 1) begin
               m_cnt  = 0;
               m_word = 1;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end else if (md == 5) begin
            m_q   = ld;
            m_cnt = 0;
         end
      end
   endtask

   // Apply one transaction, clock it, advance the model and settle
   task automatic step(input bit r, input bit e, input logic [2:0] md, input bit s, input logic [W-1:0] ld);
      reset  = r;
      en_i   = e;
      mode_i = md;
      ser_i  = s;
      load_i = ld;
      @(posedge clk);
      model_edge(r, e, int'(md), s, int'(ld));
      #1;
      txn++;
      $display("txn %0d rst=%0b en=%0b mode=%0d ser=%0b load=%h -> out=%h cnt=%0d word=%0b",
               txn, r, e, md, s, ld, out_o, count_o, word_o);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 3'b101, 1'b0, 16'hBEEF);
      checks++;
      if (out_o !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", out_o); end
      checks++;
      if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
      checks++;
      if (word_o !== 1'b0) begin errors++; $display("FAIL reset_word got %b want 0", word_o); end
   endtask

   task automatic test_legacy_shift();
      bit bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b001, bits[i], 16'h0);
      checks++;
      if (out_o !== 16'h000B) begin errors++; $display("FAIL legacy_out got %h want 000b", out_o); end
      checks++;
      if (count_o !== 4'd4) begin errors++; $display("FAIL legacy_count got %0d want 4", count_o); end
      checks++;
      if (ser_o !== 1'b0) begin errors++; $display("FAIL legacy_ser got %b want 0", ser_o); end
   endtask

   task automatic test_rotate_load();
      step(1'b0, 1'b1, 3'b101, 1'b0, 16'h8001);
      checks++;
      if (count_o !== 4'd0) begin errors++; $display("FAIL load_count got %0d want 0", count_o); end
      checks++;
      if (out_o !== 16'h8001) begin errors++; $display("FAIL load_out got %h want 8001", out_o); end
      step(1'b0, 1'b1, 3'b011, 1'b1, 16'h0);
      checks++;
      if (out_o !== 16'h0003) begin errors++; $display("FAIL rol_out got %h want 0003", out_o); end
      step(1'b0, 1'b1, 3'b101, 1'b0, 16'h8001);
      step(1'b0, 1'b1, 3'b100, 1'b1, 16'h0);
      checks++;
      if (out_o !== 16'hC000) begin errors++; $display("FAIL ror_out got %h want c000", out_o); end
      checks++;
      if (ser_o !== 1'b0) begin errors++; $display("FAIL ror_ser got %b want 0", ser_o); end
      step(1'b0, 1'b1, 3'b101, 1'b0, 16'h0001);
      step(1'b0, 1'b1, 3'b010, 1'b1, 16'h0);
      checks++;
      if (out_o !== 16'h8000) begin errors++; $display("FAIL shr_out got %h want 8000", out_o); end
   endtask

   task automatic test_deserialise();
      logic [15:0] pat;
      pat = 16'hA5A5;
      step(1'b1, 1'b0, 3'b000, 1'b0, 16'h0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 3'b001, pat[15-i], 16'h0);
         checks++;
         if (word_o !== (i == 15)) begin
            errors++; $display("FAIL deser_word edge %0d got %b want %b", i, word_o, (i == 15));
         end
      end
      checks++;
      if (out_o !== 16'hA5A5) begin errors++; $display("FAIL deser_out got %h want a5a5", out_o); end
      checks++;
      if (count_o !== 4'd0) begin errors++; $display("FAIL deser_count got %0d want 0", count_o); end
      step(1'b0, 1'b1, 3'b000, 1'b0, 16'h0);
      checks++;
      if (word_o !== 1'b0) begin errors++; $display("FAIL deser_pulse_len got %b want 0", word_o); end
   endtask

   task automatic test_stall();
      logic [15:0] pat;
      logic [15:0] frozen;
      int cycle;
      int pulse_cycle;
      pat         = 16'hA5A5;
      cycle       = 0;
      pulse_cycle = -1;
      step(1'b1, 1'b0, 3'b000, 1'b0, 16'h0);
      for (int i = 0; i < 16; i++) begin
         if (i == 5) begin
            frozen = out_o;
            checks++;
            if (count_o !== 4'd5) begin errors++; $display("FAIL stall_at5 got %0d want 5", count_o); end
            // three disabled cycles, then reserved modes 110 and 111 with en high
            for (int k = 0; k < 5; k++) begin
               if (k < 3) step(1'b0, 1'b0, 3'b001, 1'b1, 16'hFFFF);
               else       step(1'b0, 1'b1, (k == 3) ? 3'b110 : 3'b111, 1'b1, 16'hFFFF);
               cycle++;
               checks++;
               if (out_o !== frozen || count_o !== 4'd5 || word_o !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_freeze k=%0d got out=%h cnt=%0d word=%b want out=%h cnt=5 word=0",
                           k, out_o, count_o, word_o, frozen);
               end
            end
         end
         step(1'b0, 1'b1, 3'b001, pat[15-i], 16'h0);
         cycle++;
         if (word_o === 1'b1 && pulse_cycle < 0) pulse_cycle = cycle;
      end
      checks++;
      if (pulse_cycle !== 21) begin errors++; $display("FAIL stall_pulse_cycle got %0d want 21", pulse_cycle); end
      checks++;
      if (out_o !== 16'hA5A5) begin errors++; $display("FAIL stall_out got %h want a5a5", out_o); end
   endtask

   task automatic test_reset_midword();
      int pulses;
      int pulse_at;
      pulses   = 0;
      pulse_at = -1;
      step(1'b1, 1'b0, 3'b000, 1'b0, 16'h0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 3'b001, 1'($urandom_range(0, 1)), 16'h0);
      checks++;
      if (count_o !== 4'd7) begin errors++; $display("FAIL mid_count7 got %0d want 7", count_o); end
      step(1'b1, 1'b1, 3'b001, 1'b1, 16'h0);
      checks++;
      if (out_o !== 16'h0 || count_o !== 4'd0 || word_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got out=%h cnt=%0d word=%b want 0000/0/0", out_o, count_o, word_o);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 3'b001, 1'($urandom_range(0, 1)), 16'h0);
         if (word_o === 1'b1) begin pulses++; pulse_at = i; end
      end
      checks++;
      if (pulses !== 1 || pulse_at !== 15) begin
         errors++; $display("FAIL mid_pulses got %0d at %0d want 1 at 15", pulses, pulse_at);
      end
   endtask

   task automatic test_random();
      logic [2:0]   md;
      logic [15:0]  ld;
      bit           e, s, r;
      bit           exp_ser;
      step(1'b1, 1'b0, 3'b000, 1'b0, 16'h0);
      for (int i = 0; i < 300; i++) begin
         md = 3'($urandom_range(0, 7));
         e  = ($urandom_range(0, 9) != 0);
         r  = ($urandom_range(0, 49) == 0);
         s  = 1'($urandom_range(0, 1));
         ld = 16'($urandom);
         mode_i = md;
         #1;
         exp_ser = (md == 3'd2 || md == 3'd4) ? bit'(m_q % 2) : bit'(m_q / (1 << (W - 1)));
         checks++;
         if (ser_o !== exp_ser) begin
            errors++; $display("FAIL rnd_ser i=%0d got %b want %b", i, ser_o, exp_ser);
         end
         step(r, e, md, s, ld);
         checks++;
         if (out_o !== 16'(m_q) || count_o !== 4'(m_cnt) || word_o !== m_word) begin
            errors++;
            $display("FAIL rnd_state i=%0d got out=%h cnt=%0d word=%b want out=%h cnt=%0d word=%b",
                     i, out_o, count_o, word_o, 16'(m_q), m_cnt, m_word);
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      en_i   = 1'b0;
      mode_i = 3'b000;
      ser_i  = 1'b0;
      load_i = '0;
      m_q    = 0;
      m_cnt  = 0;
      m_word = 0;
      test_reset();
      test_legacy_shift();
      test_rotate_load();
      test_deserialise();
      test_stall();
      test_reset_midword();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the fixed 16-bit serial-in shift register. Adds selectable modes: shift left, shift right, rotate left, rotate right, parallel load and hold.
- Adds a serial output and a shift counter that flags each completed WIDTH-bit word.
- Used as a serialiser/deserialiser and general bit-manipulation register in the CPU datapath and I/O glue.

Parameters:
- WIDTH, 16, register width in bits; legal range is WIDTH >= 2.
- RESET_VALUE, 0, value loaded into the register on reset; WIDTH bits wide.
- CW, $clog2(WIDTH), width of count_o; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en_i  input  1  operation enable; when low, all state holds.
- mode_i  input  3  operation select (encoding below).
- ser_i  input  1  serial data in.
- load_i  input  WIDTH  parallel load data.
- out_o  output  WIDTH  register contents.
- ser_o  output  1  serial data out (combinational from the register).
- count_o  output  CW  number of shifts/rotates since the last word boundary, load or reset.
- word_o  output  1  one-cycle pulse marking a completed WIDTH-bit word.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset dominates en_i and mode_i. On a rising edge with reset=1: out_o=RESET_VALUE, count_o=0, word_o=0.
- Mode encoding, applied only when en_i=1 (q is the current register value):
  - 000 hold: q unchanged.
  - 001 SHL: q <= {q[WIDTH-2:0], ser_i}. With en_i this is identical to the legacy block.
  - 010 SHR: q <= {ser_i, q[WIDTH-1:1]}.
  - 011 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; ser_i ignored.
  - 100 ROR: q <= {q[0], q[WIDTH-1:1]}; ser_i ignored.
  - 101 LOAD: q <= load_i.
  - 110, 111: reserved, treated exactly as hold. No counter change, word_o=0.
- en_i=0: q and count_o hold; word_o=0 on the next edge.
- ser_o:
  - Equals q[0] when mode_i is 010 or 100.
  - Equals q[WIDTH-1] for all other mode_i values.
  - Purely combinational: the bit that the next SHL/SHR would shift out.
- Counter:
  - Counted ops are modes 001-100 with en_i=1.
  - A counted op with count_o < WIDTH-1 increments count_o; word_o is 0 next cycle.
  - A counted op with count_o == WIDTH-1 wraps count_o to 0 and registers word_o=1 on the same edge that updates out_o with the final bit. word_o is high for exactly one cycle unless the next op wraps again (impossible for WIDTH >= 2).
  - LOAD clears count_o to 0 and word_o to 0.
  - Hold and reserved modes leave count_o unchanged; word_o=0.
- Latency: every update is visible on out_o one cycle after the sampling edge. word_o is aligned with out_o holding the full word.
- Mode may change every cycle. Mixing shift directions within a word still counts each op; no direction tracking.
- Reset mid-word discards the partial word; there is no word_o pulse.

Test Plan:
- Reset precedence: WIDTH=16, reset=1 with en_i=1, mode=101, load_i=0xBEEF for one edge -> out_o=0x0000, count_o=0, word_o=0.
- Legacy shift: mode=001, ser_i=1,0,1,1 on four edges -> out_o=0x000B, count_o=4, ser_o=0.
- Rotates and load:
  - Load 0x8001 -> count_o=0.
  - ROL once -> out_o=0x0003.
  - Reload 0x8001, ROR once -> out_o=0xC000, ser_o=0 while mode=100.
  - SHR with ser_i=1 from 0x0001 -> out_o=0x8000.
- Deserialise: 16 SHL edges feeding 0xA5A5 MSB-first -> after the 16th edge out_o=0xA5A5, word_o=1 for exactly one cycle, count_o=0.
- Stall: during the word above, deassert en_i for 3 cycles at count_o=5 -> out_o/count_o frozen, word_o pulse delayed exactly 3 cycles. Mode 110/111 cycles behave identically to the stall.
- Reset mid-word: reset at count_o=7 -> next cycle out_o=0, count_o=0, no word_o pulse. 16 subsequent SHL edges -> a single word_o pulse.
